qspi_master: RTL and testbench

Single-word SPI/Dual/Quad SPI master that shifts one DATA_WIDTH-bit word per trigger over a shared 4-bit tri-state IO bus. It sits between a local register or command interface and an external serial flash or peripheral. It generates chip select and SCLK from the system clock. Mode (1/2/4 lines) and direction (read/write) are chosen per transaction.

---
 rtl/qspi_pkg.sv | 40 ++++
 rtl/qspi_sclk_gen.sv | 58 +++++
 rtl/qspi_master.sv | 172 +++++++++++++++++
 tb/tb_qspi_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// -----------------------------------------------------------------------------
// qspi_pkg
// Shared declarations for the SPI/Dual/Quad master: FSM state encoding,
// line-mode and direction constants, and small lane-decoding helpers.
// -----------------------------------------------------------------------------
package qspi_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRANSFER = 2'd1,
      FINISH   = 2'd2
   } state_t;

   localparam logic [1:0] MODE_SPI  = 2'b00;
   localparam logic [1:0] MODE_DUAL = 2'b01;
   localparam logic [1:0] MODE_QUAD = 2'b10;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   // Map the reserved encoding onto plain SPI so the rest of the design
   // only ever sees the three legal modes.
   function automatic logic [1:0] norm_mode(input logic [1:0] mode);
      case (mode)
         MODE_DUAL: return MODE_DUAL;
         MODE_QUAD: return MODE_QUAD;
         default:   return MODE_SPI;
      endcase
   endfunction

   // IO lanes the master drives on a write (bit i = IO[i]).
   function automatic logic [3:0] lane_mask(input logic [1:0] mode);
      case (mode)
         MODE_DUAL: return 4'b0011;
         MODE_QUAD: return 4'b1111;
         default:   return 4'b0001;
      endcase
   endfunction

endpackage

// File: rtl/qspi_sclk_gen.sv
// -----------------------------------------------------------------------------
// qspi_sclk_gen
// Divides sys_clk down to SCLK while enabled and flags each SCLK edge.
// Ports:
//   sys_clk     system clock
//   nrst        synchronous active-high reset
//   en          run the divider (held at CPOL when low)
//   sclk        registered serial clock
//   lead_edge   high in the sys_clk cycle whose rising edge makes the leading SCLK edge
//   trail_edge  high in the sys_clk cycle whose rising edge makes the trailing SCLK edge
// -----------------------------------------------------------------------------
module qspi_sclk_gen
   import qspi_pkg::*;
#(
   parameter int SCLK_DIV = 4,
   parameter bit CPOL     = 1'b0
) (
   input  logic sys_clk,
   input  logic nrst,
   input  logic en,
   output logic sclk,
   output logic lead_edge,
   output logic trail_edge
);

   localparam int HALF = SCLK_DIV / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] half_cnt_r;
   logic          sclk_r;
   logic          tick_s;

   assign tick_s = en && (half_cnt_r == CNT_LAST);
   // While SCLK sits at its idle level the next toggle is a leading edge.
   assign lead_edge  = tick_s && (sclk_r == CPOL);
   assign trail_edge = tick_s && (sclk_r != CPOL);
   assign sclk       = sclk_r;

   // Half-period counter and SCLK toggle flop.
   always_ff @(posedge sys_clk) begin
      if (nrst) begin
         half_cnt_r <= CNT_ZERO;
         sclk_r     <= CPOL;
      end else if (!en) begin
         half_cnt_r <= CNT_ZERO;
         sclk_r     <= CPOL;
      end else if (tick_s) begin
         half_cnt_r <= CNT_ZERO;
         sclk_r     <= ~sclk_r;
      end else begin
         half_cnt_r <= half_cnt_r + CNT_ONE;
      end
   end

endmodule

// File: rtl/qspi_master.sv
// -----------------------------------------------------------------------------
// qspi_master
// Shifts one DATA_WIDTH-bit word per request over SPI (1 line), Dual (2) or
// Quad (4) lanes of a shared tri-state IO bus, MSB first.
// Ports:
//   sys_clk, nrst           clock and synchronous active-high reset
//   sel_mode                00 SPI, 01 Dual, 10 Quad, 11 treated as SPI
//   operation               0 read, 1 write
//   trigger_transmission    level request; sampled only in IDLE
//   wr_data                 word to send on a write
//   rd_data                 last word received by a read
//   chip_select             active-low slave select
//   sclk                    serial clock
//   IO                      bidirectional data lanes, 'z' when not driven
// -----------------------------------------------------------------------------
module qspi_master
   import qspi_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0,
   parameter int SCLK_DIV   = 4
) (
   input  logic                  sys_clk,
   input  logic                  nrst,
   input  logic [1:0]            sel_mode,
   input  logic                  operation,
   input  logic                  trigger_transmission,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  chip_select,
   output logic                  sclk,
   inout  wire  [3:0]            IO
);

   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] BEAT_ZERO = BW'(0);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
   localparam logic [BW-1:0] LAST_SPI  = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_DUAL = BW'(DATA_WIDTH / 2 - 1);
   localparam logic [BW-1:0] LAST_QUAD = BW'(DATA_WIDTH / 4 - 1);
   localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

   state_t                current_state;
   logic [1:0]            mode_r;
   logic                  op_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  cs_r;
   logic [3:0]            io_oe_r;
   logic [BW-1:0]         beat_cnt_r;

   logic                  sclk_s;
   logic                  lead_edge_s;
   logic                  trail_edge_s;
   logic                  sample_edge_s;
   logic                  shift_edge_s;
   logic                  last_beat_s;
   logic [BW-1:0]         last_idx_s;
   logic [3:0]            io_out_s;
   logic [DATA_WIDTH-1:0] sampled_s;
   logic [DATA_WIDTH-1:0] shifted_s;

   qspi_sclk_gen #(
      .SCLK_DIV (SCLK_DIV),
      .CPOL     (CPOL)
   ) u_sclk_gen (
      .sys_clk    (sys_clk),
      .nrst       (nrst),
      .en         (current_state == TRANSFER),
      .sclk       (sclk_s),
      .lead_edge  (lead_edge_s),
      .trail_edge (trail_edge_s)
   );

   // With CPHA=1 the first beat is already on the lanes from latch time,
   // so only later leading edges advance the write shift register.
   assign sample_edge_s = CPHA ? trail_edge_s : lead_edge_s;
   assign shift_edge_s  = CPHA ? (lead_edge_s && (beat_cnt_r != BEAT_ZERO)) : trail_edge_s;
   assign last_beat_s   = trail_edge_s && (beat_cnt_r == last_idx_s);

   // Lane decode: outgoing beat, incoming sample and beat count per mode.
   always_comb begin
      io_out_s   = 4'b0000;
      last_idx_s = LAST_SPI;
      sampled_s  = shift_r;
      shifted_s  = shift_r;
      case (mode_r)
         MODE_DUAL: begin
            io_out_s   = {2'b00, shift_r[DATA_WIDTH-2], shift_r[DATA_WIDTH-1]};
            last_idx_s = LAST_DUAL;
            sampled_s  = (shift_r << 2) | DATA_WIDTH'({IO[0], IO[1]});
            shifted_s  = shift_r << 2;
         end
         MODE_QUAD: begin
            io_out_s   = {shift_r[DATA_WIDTH-4], shift_r[DATA_WIDTH-3],
                          shift_r[DATA_WIDTH-2], shift_r[DATA_WIDTH-1]};
            last_idx_s = LAST_QUAD;
            sampled_s  = (shift_r << 4) | DATA_WIDTH'({IO[0], IO[1], IO[2], IO[3]});
            shifted_s  = shift_r << 4;
         end
         default: begin
            io_out_s   = {3'b000, shift_r[DATA_WIDTH-1]};
            last_idx_s = LAST_SPI;
            sampled_s  = (shift_r << 1) | DATA_WIDTH'(IO[1]);
            shifted_s  = shift_r << 1;
         end
      endcase
   end

   // Transaction FSM with datapath and registered pin controls.
   always_ff @(posedge sys_clk) begin
      if (nrst) begin
         current_state <= IDLE;
         mode_r        <= MODE_SPI;
         op_r          <= OP_READ;
         shift_r       <= WORD_ZERO;
         rd_data_r     <= WORD_ZERO;
         cs_r          <= 1'b1;
         io_oe_r       <= 4'b0000;
         beat_cnt_r    <= BEAT_ZERO;
      end else begin
         case (current_state)
            IDLE: begin
               if (trigger_transmission) begin
                  mode_r        <= norm_mode(sel_mode);
                  op_r          <= operation;
                  shift_r       <= (operation == OP_WRITE) ? wr_data : WORD_ZERO;
                  beat_cnt_r    <= BEAT_ZERO;
                  cs_r          <= 1'b0;
                  io_oe_r       <= (operation == OP_WRITE) ? lane_mask(norm_mode(sel_mode)) : 4'b0000;
                  current_state <= TRANSFER;
               end
            end
            TRANSFER: begin
               if (op_r == OP_READ && sample_edge_s) begin
                  shift_r <= sampled_s;
               end else if (op_r == OP_WRITE && shift_edge_s) begin
                  shift_r <= shifted_s;
               end
               if (trail_edge_s) begin
                  beat_cnt_r <= beat_cnt_r + BEAT_ONE;
               end
               if (last_beat_s) begin
                  cs_r          <= 1'b1;
                  io_oe_r       <= 4'b0000;
                  current_state <= FINISH;
                  // With CPHA=1 the final sample lands on this very edge.
                  if (op_r == OP_READ) begin
                     rd_data_r <= sample_edge_s ? sampled_s : shift_r;
                  end
               end
            end
            FINISH: begin
               current_state <= IDLE;
            end
            default: begin
               current_state <= IDLE;
            end
         endcase
      end
   end

   assign chip_select = cs_r;
   assign sclk        = sclk_s;
   assign rd_data     = rd_data_r;
   assign IO[0] = io_oe_r[0] ? io_out_s[0] : 1'bz;
   assign IO[1] = io_oe_r[1] ? io_out_s[1] : 1'bz;
   assign IO[2] = io_oe_r[2] ? io_out_s[2] : 1'bz;
   assign IO[3] = io_oe_r[3] ? io_out_s[3] : 1'bz;

endmodule

// File: tb/tb_qspi_master.sv
// -----------------------------------------------------------------------------
// tb_qspi_master
// Scoreboard bench for qspi_master with default parameters (8-bit word,
// CPOL=0, CPHA=0, SCLK_DIV=4). Expected beats and read results are queued
// when a transaction is issued and compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_qspi_master;
   import qspi_pkg::*;

   typedef struct {
      logic [3:0] val;
      logic [3:0] mask;
      logic [3:0] oe;
   } beat_t;

   typedef struct {
      logic [7:0] rd;
      int         n;
   } txn_t;

   logic       clk = 1'b0;
   logic       nrst;
   logic [1:0] sel_mode;
   logic       operation;
   logic       trigger_transmission;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       chip_select;
   logic       sclk;
   wire  [3:0] io;

   logic [3:0] slv_drv = 4'b0000;
   logic [3:0] slv_oe  = 4'b0000;
   logic       slv_active = 1'b0;
   logic [7:0] slv_word = 8'h00;
   int         slv_l = 1;
   int         slv_beat = 0;

   beat_t beat_q[$];
   txn_t  txn_q[$];
   logic [7:0] exp_rd = 8'h00;
   logic       mon_en = 1'b0;
   int         fin_cnt = 0;
   int         rise_cnt = 0;
   int         vec_cnt = 0;
   int         miscompare_cnt = 0;

   assign io[0] = slv_oe[0] ? slv_drv[0] : 1'bz;
   assign io[1] = slv_oe[1] ? slv_drv[1] : 1'bz;
   assign io[2] = slv_oe[2] ? slv_drv[2] : 1'bz;
   assign io[3] = slv_oe[3] ? slv_drv[3] : 1'bz;

   qspi_master dut (
      .sys_clk              (clk),
      .nrst                 (nrst),
      .sel_mode             (sel_mode),
      .operation            (operation),
      .trigger_transmission (trigger_transmission),
      .wr_data              (wr_data),
      .rd_data              (rd_data),
      .chip_select          (chip_select),
      .sclk                 (sclk),
      .IO                   (io)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miscompare_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lanes_of(input logic [1:0] m);
      case (m)
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 1;
      endcase
   endfunction

   // Lane i of beat b carries word bit (7 - l*b - i): MSB first, IO0 highest.
   function automatic logic [3:0] beat_lanes(input logic [7:0] w, input int l, input int b);
      logic [3:0] v;
      v = 4'b0000;
      for (int i = 0; i < l; i++) v[i] = w[7 - l*b - i];
      return v;
   endfunction

   task automatic push_txn(input logic [1:0] m, input logic op, input logic [7:0] wd, input logic [7:0] sd);
      int    l;
      beat_t bt;
      txn_t  t;
      l = lanes_of(m);
      for (int b = 0; b < 8 / l; b++) begin
         bt.oe   = op ? 4'((1 << l) - 1) : 4'b0000;
         bt.mask = bt.oe;
         bt.val  = beat_lanes(wd, l, b) & bt.mask;
         beat_q.push_back(bt);
      end
      if (!op) exp_rd = sd;
      t.rd = exp_rd;
      t.n  = 8 / l;
      txn_q.push_back(t);
   endtask

   task automatic wait_cs_low();
      int n;
      n = 0;
      while (chip_select && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("cs_fall_latency", n, 1);
   endtask

   task automatic wait_finish(input int target);
      for (int i = 0; i < 200 && fin_cnt < target; i++) @(negedge clk);
      check("finish_reached", 32'(fin_cnt >= target), 32'd1);
   endtask

   task automatic run_txn(input logic [1:0] m, input logic op, input logic [7:0] wd, input logic [7:0] sd);
      int target;
      target = fin_cnt + 1;
      push_txn(m, op, wd, sd);
      slv_word   = sd;
      slv_l      = lanes_of(m);
      slv_active = !op;
      sel_mode   = m;
      operation  = op;
      wr_data    = wd;
      trigger_transmission = 1'b1;
      wait_cs_low();
      // Scramble inputs mid-transfer; they must not matter.
      trigger_transmission = 1'b0;
      sel_mode  = ~m;
      operation = ~op;
      wr_data   = ~wd;
      wait_finish(target);
      @(negedge clk);
      slv_active = 1'b0;
   endtask

   // Slave model and output monitor, all sampled on the falling sys_clk edge.
   initial begin
      logic prev_sclk;
      logic prev_cs;
      logic [3:0] v;
      beat_t bt;
      txn_t  t;
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
      forever begin
         @(negedge clk);
         if (!chip_select && slv_active) begin
            if (prev_cs) slv_beat = 0;
            else if (!sclk && prev_sclk) slv_beat++;
            v = beat_lanes(slv_word, slv_l, slv_beat);
            if (slv_l == 1) begin
               slv_drv = {2'b00, v[0], 1'b0};
               slv_oe  = 4'b0010;
            end else begin
               slv_drv = v;
               slv_oe  = 4'((1 << slv_l) - 1);
            end
         end else begin
            slv_oe = 4'b0000;
         end
         if (!chip_select && prev_cs) rise_cnt = 0;
         if (mon_en && sclk && !prev_sclk) begin
            rise_cnt++;
            if (beat_q.size() == 0) begin
               check("beat_queue_level", beat_q.size(), 1);
            end else begin
               bt = beat_q.pop_front();
               check("io_drive_enable", dut.io_oe_r, bt.oe);
               if (bt.mask != 4'b0000) check("io_lanes", io & bt.mask, bt.val);
            end
         end
         if (mon_en && dut.current_state == FINISH) begin
            fin_cnt++;
            check("finish_cs_high", chip_select, 1);
            check("finish_io_released", dut.io_oe_r, 0);
            if (txn_q.size() == 0) begin
               check("txn_queue_level", txn_q.size(), 1);
            end else begin
               t = txn_q.pop_front();
               check("rd_data", rd_data, t.rd);
               check("sclk_periods", rise_cnt, t.n);
            end
         end
         prev_sclk = sclk;
         prev_cs   = chip_select;
      end
   end

   initial begin
      int gap;
      int target;
      nrst = 1'b1;
      sel_mode = 2'b00;
      operation = OP_READ;
      trigger_transmission = 1'b0;
      wr_data = 8'h00;
      repeat (3) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      check("reset_cs", chip_select, 1);
      check("reset_sclk", sclk, 0);
      check("reset_rd_data", rd_data, 8'h00);
      check("reset_state", 32'(dut.current_state), 32'(IDLE));
      check("reset_io", dut.io_oe_r, 0);
      mon_en = 1'b1;

      run_txn(MODE_SPI,  OP_READ,  8'h00, 8'hFF);
      run_txn(MODE_DUAL, OP_READ,  8'h00, 8'hFF);
      run_txn(MODE_QUAD, OP_READ,  8'h00, 8'hA5);
      run_txn(MODE_SPI,  OP_WRITE, 8'hA5, 8'h00);
      run_txn(MODE_DUAL, OP_WRITE, 8'h5A, 8'h00);
      run_txn(MODE_QUAD, OP_WRITE, 8'hF0, 8'h00);
      run_txn(2'b11,     OP_READ,  8'h00, 8'h3C);
      run_txn(MODE_SPI,  OP_READ,  8'h00, 8'h96);
      run_txn(MODE_DUAL, OP_READ,  8'h00, 8'h69);

      // Back-to-back: trigger held, second request latched from the new inputs.
      target = fin_cnt;
      push_txn(MODE_DUAL, OP_WRITE, 8'h5A, 8'h00);
      push_txn(MODE_QUAD, OP_WRITE, 8'h81, 8'h00);
      sel_mode = MODE_DUAL;
      operation = OP_WRITE;
      wr_data = 8'h5A;
      trigger_transmission = 1'b1;
      wait_cs_low();
      sel_mode = MODE_QUAD;
      wr_data = 8'h81;
      for (int i = 0; i < 100 && dut.current_state != FINISH; i++) @(negedge clk);
      gap = 0;
      while (chip_select && gap < 10) begin
         gap++;
         @(negedge clk);
      end
      check("b2b_cs_high_cycles", gap, 2);
      trigger_transmission = 1'b0;
      sel_mode = MODE_SPI;
      operation = OP_READ;
      wr_data = 8'h00;
      wait_finish(target + 2);
      @(negedge clk);

      // Reset in the middle of a quad write.
      mon_en = 1'b0;
      sel_mode = MODE_QUAD;
      operation = OP_WRITE;
      wr_data = 8'hFF;
      trigger_transmission = 1'b1;
      wait_cs_low();
      trigger_transmission = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_reset_cs_low", chip_select, 0);
      nrst = 1'b1;
      @(negedge clk);
      nrst = 1'b0;
      check("abort_cs", chip_select, 1);
      check("abort_sclk", sclk, 0);
      check("abort_io", dut.io_oe_r, 0);
      check("abort_state", 32'(dut.current_state), 32'(IDLE));
      check("abort_rd_data", rd_data, 8'h00);
      exp_rd = 8'h00;
      @(negedge clk);
      mon_en = 1'b1;
      run_txn(MODE_QUAD, OP_READ, 8'h00, 8'h5A);
      run_txn(MODE_SPI,  OP_WRITE, 8'h3C, 8'h00);

      check("beat_queue_drained", beat_q.size(), 0);
      check("txn_queue_drained", txn_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
      $finish;
   end

endmodule
